// File: rtl/clock_pkg.sv
// clock_pkg: shared time-of-day field limits, word layout and helpers
package clock_pkg;
  localparam int TF_W = 8;
  localparam logic [TF_W-1:0] HOUR_MAX = 8'd23;
  localparam logic [TF_W-1:0] MIN_MAX = 8'd59;
  localparam logic [TF_W-1:0] SEC_MAX = 8'd59;
  typedef struct packed {
    logic [TF_W-1:0] hour;
    logic [TF_W-1:0] min;
    logic [TF_W-1:0] sec;
  } tod_t;
  function automatic tod_t unpack_tod(input logic [3*TF_W-1:0] w);
    return tod_t'(w);
  endfunction
  function automatic logic [3*TF_W-1:0] pack_tod(input tod_t t);
    return t;
  endfunction
  function automatic logic tod_valid(input tod_t t);
    return t.hour <= HOUR_MAX && t.min <= MIN_MAX && t.sec <= SEC_MAX;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a one-cycle enable every CLK_HZ running cycles
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic sec_en
);
  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  logic [CW-1:0] cnt;
  assign sec_en = run && cnt == LAST;
  // count while running, wrap on the last cycle of the second, clear restarts the second
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (run) cnt <= sec_en ? '0 : cnt + CW'(1);
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: binary hh:mm:ss counter with load, alarm and 12/24-hour view
module rtc_timekeeper
  import clock_pkg::*;
#(
  parameter int          CLK_HZ    = 50_000_000,
  parameter logic [23:0] INIT_TIME = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mode12,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        alm_wr,
  input  logic [23:0] alm_time,
  input  logic        alm_en,
  output logic [23:0] data_out,
  output logic [23:0] disp_out,
  output logic        pm,
  output logic        tick,
  output logic        alarm_hit,
  output logic        load_err
);
  tod_t cur, nxt, ld, alm, alm_nxt;
  logic sec_en, ld_ok;
  logic [TF_W-1:0] h12;
  assign ld = unpack_tod(load_time);
  assign ld_ok = load && tod_valid(ld);
  assign alm_nxt = alm_wr ? tod_t'({alm_time[23:8], 8'h00}) : alm;
  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clr   (ld_ok),
    .sec_en(sec_en)
  );
  // next time value; an accepted load takes priority over the second enable
  always_comb begin
    nxt = cur;
    if (ld_ok) nxt = ld;
    else if (sec_en) begin
      nxt.sec  = cur.sec == SEC_MAX ? '0 : cur.sec + 8'd1;
      nxt.min  = cur.sec != SEC_MAX ? cur.min : cur.min == MIN_MAX ? '0 : cur.min + 8'd1;
      nxt.hour = !(cur.sec == SEC_MAX && cur.min == MIN_MAX) ? cur.hour :
                 cur.hour == HOUR_MAX ? '0 : cur.hour + 8'd1;
    end
  end
  // time/alarm registers and status pulses; alarm only fires on a time-changing event
  always_ff @(posedge clk)
    if (rst) begin
      cur       <= unpack_tod(INIT_TIME);
      alm       <= '0;
      tick      <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cur       <= nxt;
      alm       <= alm_nxt;
      tick      <= sec_en && !ld_ok;
      alarm_hit <= alm_en && (ld_ok || sec_en) && nxt == alm_nxt;
      load_err  <= load && !ld_ok;
    end
  assign data_out = pack_tod(cur);
  assign pm = cur.hour >= 8'd12;
  assign h12 = cur.hour == '0 ? 8'd12 : cur.hour > 8'd12 ? cur.hour - 8'd12 : cur.hour;
  assign disp_out = mode12 ? {h12, cur.min, cur.sec} : data_out;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: random and directed checks against a seconds-of-day model
module tb_rtc_timekeeper;
  localparam int HZ = 10;
  localparam int DAY = 86400;
  logic clk = 0, rst = 1, run = 0, mode12 = 0, load = 0, alm_wr = 0, alm_en = 0;
  logic [23:0] load_time = '0, alm_time = '0;
  logic [23:0] data_out, disp_out;
  logic pm, tick, alarm_hit, load_err;
  int n_cmp = 0, n_bad = 0;
  int tod = 0, pc = 0, alm_h = 0, alm_m = 0;
  bit e_tick = 0, e_hit = 0, e_err = 0;
  int ticks = 0, hits = 0, errs = 0;

  always #5 clk = ~clk;

  rtc_timekeeper #(.CLK_HZ(HZ), .INIT_TIME(24'h000000)) dut (
    .clk(clk), .rst(rst), .run(run), .mode12(mode12), .load(load),
    .load_time(load_time), .alm_wr(alm_wr), .alm_time(alm_time), .alm_en(alm_en),
    .data_out(data_out), .disp_out(disp_out), .pm(pm), .tick(tick),
    .alarm_hit(alarm_hit), .load_err(load_err)
  );

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] tw(input int t);
    return {8'(t / 3600), 8'((t / 60) % 60), 8'(t % 60)};
  endfunction

  function automatic logic [23:0] disp_of(input int t, input bit m12);
    int h;
    h = t / 3600;
    if (m12) h = (h % 12 == 0) ? 12 : h % 12;
    return {8'(h), 8'((t / 60) % 60), 8'(t % 60)};
  endfunction

  task automatic cyc();
    int lh, lm, ls;
    bit ok, sen;
    lh = int'(load_time[23:16]); lm = int'(load_time[15:8]); ls = int'(load_time[7:0]);
    if (rst) begin
      tod = 0; pc = 0; alm_h = 0; alm_m = 0; e_tick = 0; e_hit = 0; e_err = 0;
    end else begin
      ok = load && lh <= 23 && lm <= 59 && ls <= 59;
      sen = run && pc == HZ - 1;
      if (alm_wr) begin alm_h = int'(alm_time[23:16]); alm_m = int'(alm_time[15:8]); end
      if (ok) pc = 0; else if (run) pc = (pc + 1) % HZ;
      e_err = load && !ok;
      e_tick = sen && !ok;
      if (ok) tod = lh * 3600 + lm * 60 + ls; else if (sen) tod = (tod + 1) % DAY;
      e_hit = alm_en && (ok || sen) && alm_h == tod / 3600 && alm_m == (tod / 60) % 60 && tod % 60 == 0;
    end
    @(posedge clk);
    #1;
    load = 0; alm_wr = 0;
    check("data_out", data_out, tw(tod));
    check("disp_out", disp_out, disp_of(tod, mode12));
    check("pm", 24'(pm), 24'(tod >= 12 * 3600));
    check("tick", 24'(tick), 24'(e_tick));
    check("alarm_hit", 24'(alarm_hit), 24'(e_hit));
    check("load_err", 24'(load_err), 24'(e_err));
    ticks += int'(tick); hits += int'(alarm_hit); errs += int'(load_err);
  endtask

  task automatic do_load(input logic [23:0] v);
    load = 1; load_time = v; cyc();
  endtask

  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin cyc(); n++; end while (!tick && n < lim);
  endtask

  initial begin
    int n, t0, h0, e0;
    int hrs[5] = '{0, 1, 12, 13, 23};
    int dh[5] = '{12, 1, 12, 1, 11};
    int dp[5] = '{0, 0, 1, 1, 1};
    cyc(); cyc();
    check("rst_data", data_out, 24'h000000);
    rst = 0; run = 1;
    t0 = ticks;
    repeat (9) cyc();
    check("no_early_tick", 24'(ticks - t0), 24'd0);
    cyc();
    check("first_tick", 24'(tick), 24'd1);
    check("first_sec", data_out, 24'h000001);

    do_load(24'h173B3A);
    check("load_vis", data_out, 24'h173B3A);
    repeat (10) cyc();
    check("t_235959", data_out, 24'h173B3B);
    repeat (10) cyc();
    check("day_wrap", data_out, 24'h000000);

    e0 = errs;
    do_load(24'h183B00);
    check("err_hold", data_out, 24'h000000);
    check("err_once", 24'(errs - e0), 24'd1);
    n = 0;
    while (pc != HZ - 1 && n < 2 * HZ) begin cyc(); n++; end
    do_load(24'h010203);
    check("load_wins", data_out, 24'h010203);
    check("load_no_tick", 24'(tick), 24'd0);

    alm_en = 1; alm_wr = 1; alm_time = 24'h0A0000;
    do_load(24'h093B3B);
    h0 = hits;
    repeat (30) cyc();
    check("alarm_once", 24'(hits - h0), 24'd1);
    alm_en = 0;
    do_load(24'h093B3B);
    h0 = hits;
    repeat (30) cyc();
    check("alarm_off", 24'(hits - h0), 24'd0);

    run = 0; mode12 = 1;
    for (int i = 0; i < 5; i++) begin
      do_load({8'(hrs[i]), 8'h1E, 8'h05});
      check("disp12", disp_out, {8'(dh[i]), 8'h1E, 8'h05});
      check("pm12", 24'(pm), 24'(dp[i]));
    end
    mode12 = 0;

    do_load(24'h000000);
    run = 1;
    repeat (4) cyc();
    run = 0;
    repeat (25) cyc();
    check("pause_hold", data_out, 24'h000000);
    run = 1;
    wait_tick(3 * HZ, n);
    check("resume_rem", 24'(n), 24'd6);
    repeat (3) cyc();
    rst = 1; cyc(); rst = 0;
    check("rst_mid", data_out, 24'h000000);
    wait_tick(3 * HZ, n);
    check("rst_cnt0", 24'(n), 24'd10);

    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 499) == 0;
      run = $urandom_range(0, 9) != 0;
      mode12 = 1'($urandom);
      alm_en = $urandom_range(0, 3) != 0;
      alm_wr = $urandom_range(0, 99) == 0;
      alm_time = {8'($urandom_range(0, 25)), 8'($urandom_range(0, 61)), 8'($urandom)};
      load = $urandom_range(0, 24) == 0;
      if ($urandom_range(0, 1) == 1 && alm_h <= 23 && alm_m <= 59)
        load_time = tw((alm_h * 3600 + alm_m * 60 - int'($urandom_range(1, 3)) + DAY) % DAY);
      else
        load_time = {8'($urandom_range(0, 25)), 8'($urandom_range(0, 62)), 8'($urandom_range(0, 62))};
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised time-of-day counter replacing the fixed 50 MHz hh:mm:ss counter in the digital clock. Derives a one-second enable from the system clock instead of a divided clock, keeps hours/minutes/seconds in binary, and adds run/pause, a validated time-load port, a single alarm and a 12/24-hour display view. Sits between the board clock/reset and the display encoder, which consumes the packed time word.

## Interface
- CLK_HZ, 50_000_000: system clock frequency; one second equals CLK_HZ cycles (minimum 2).
- INIT_TIME, 24'h000000: reset time packed {hour, min, sec}, 8 bits each, binary.
- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = count seconds; 0 = hold time and prescaler.
- mode12  in  1  selects 12-hour view on disp_out; internal time is always 24-hour.
- load  in  1  one-cycle strobe; writes load_time into the time registers.
- load_time  in  24  {hour, min, sec} to load.
- alm_wr  in  1  one-cycle strobe; writes alm_time into the alarm register.
- alm_time  in  24  {hour, min, 8'h00}; the seconds field is ignored and stored as 0.
- alm_en  in  1  alarm enable.
- data_out  out  24  current time {hour, min, sec}, 24-hour format.
- disp_out  out  24  display time; equals data_out when mode12 = 0.
- pm  out  1  1 when hour >= 12.
- tick  out  1  one-cycle pulse on the cycle the seconds field advances.
- alarm_hit  out  1  one-cycle pulse when the time reaches the alarm time.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Prescaler cnt counts 0..CLK_HZ-1 while run = 1. At cnt = CLK_HZ-1 it wraps to 0 and an internal second enable is asserted for that cycle.
- On a second enable:
  - Seconds increment.
  - At sec = 59, seconds go to 0 and minutes increment.
  - At min = 59 and sec = 59, minutes and seconds go to 0 and hours increment.
  - At 23:59:59, time goes to 00:00:00.
- run = 0 freezes both cnt and the time registers. Deasserting and reasserting run resumes from the held cnt value.
- Load is accepted only if hour <= 23, min <= 59 and sec <= 59.
  - Accepted load: time registers take load_time, cnt clears to 0, and no increment occurs in that cycle.
  - Rejected load: time registers and cnt are unchanged, and load_err pulses for one cycle.
- alm_wr stores {hour, min, 0} with no range check. An out-of-range alarm value simply never matches.
- alarm_hit pulses when alm_en = 1 and a second enable or an accepted load makes the registered time equal to the alarm register. It does not repeat while the time stays equal.
- disp_out with mode12 = 1:
  - hour 0 displays as 12.
  - hours 1..12 display unchanged.
  - hours 13..23 display as hour-12.
  - min and sec display unchanged.
  - pm is valid in both modes.
- Counter arithmetic is 8-bit per field. Comparisons are against constants; no field ever holds a value above its limit, except transiently after an unchecked alarm write (alarm register only).

## Timing
- Reset values:
  - data_out = INIT_TIME.
  - cnt = 0.
  - alarm register = 0.
  - tick, alarm_hit and load_err = 0.
  - disp_out and pm are derived from INIT_TIME.
- tick, alarm_hit and load_err are registered. tick is high on the cycle after cnt = CLK_HZ-1, which is the same cycle the new data_out value is visible.
- The first tick after reset or after an accepted load occurs on the CLK_HZ-th rising edge with run = 1.
- An accepted load is visible on data_out one cycle after the load strobe.
- alarm_hit is high in the same cycle the matching data_out value is first visible.
- disp_out and pm are combinational from data_out and mode12. There is zero added latency; a mode12 change takes effect in the same cycle.
- Load and second enable in the same cycle: load wins, the enable is discarded, and tick is not asserted.
- A rejected load does not block the second enable; counting proceeds normally.
- alm_wr and load in the same cycle: both take effect, and the match is evaluated against the new alarm value.
- rst asserted mid-count overrides all inputs in that cycle.

## Structure
- Package clock_pkg holds:
  - Field limits HOUR_MAX = 23, MIN_MAX = 59, SEC_MAX = 59.
  - Field width TF_W = 8.
  - Pack/unpack helpers for the {hour, min, sec} word.
- The display encoder shares clock_pkg.
- One sub-module, tick_gen (parameter CLK_HZ; inputs clk, rst, run, clr; output sec_en), isolates the prescaler. Time, alarm and display logic stay in rtc_timekeeper.

## Test plan
All scenarios use CLK_HZ = 10 for simulation.
- Reset, then run = 1 for 10 cycles: data_out 00:00:00 -> 00:00:01, with exactly one tick on cycle 10.
- Load 24'h173B3A (23:59:58), then run 20 cycles: 23:59:59, then 00:00:00 with no carry into a 24th hour.
- Load 24'h183B00 (hour 24): load_err pulses once and data_out is unchanged. Load and second enable in the same cycle: the loaded value wins, with no tick.
- Alarm 24'h0A0000 with alm_en = 1, load 24'h093B3B: alarm_hit pulses exactly once at 10:00:00. Repeat with alm_en = 0: no pulse.
- mode12 = 1 over hours 0, 1, 12, 13, 23: disp hours 12, 1, 12, 1, 11, with pm = 0, 0, 1, 1, 1.
- run = 0 for 25 cycles mid-second, then run = 1: data_out is held, and the next tick arrives after the remaining prescaler count. rst mid-count: data_out = INIT_TIME and cnt = 0.
